// File: rtl/sliding_window_3x3_if.sv
// Pixel stream in, 3x3 window out, for sliding_window_3x3.
// frame_cnt is present only when SW_FRAME_CNT_EN is defined.
interface sliding_window_3x3_if;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic [7:0] sw_pixels1, sw_pixels2, sw_pixels3;
    logic [7:0] sw_pixels4, sw_pixels5, sw_pixels6;
    logic [7:0] sw_pixels7, sw_pixels8, sw_pixels9;
    logic       act;
    logic       frame_done;
`ifdef SW_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport master (
        output in_valid, in_pixel,
        input  sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
               sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9,
               act, frame_done, frame_cnt
    );
    modport slave (
        input  in_valid, in_pixel,
        output sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
               sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9,
               act, frame_done, frame_cnt
    );
`else
    modport master (
        output in_valid, in_pixel,
        input  sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
               sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9,
               act, frame_done
    );
    modport slave (
        input  in_valid, in_pixel,
        output sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
               sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9,
               act, frame_done
    );
`endif
endinterface

// File: rtl/sliding_window_3x3.sv
// Two-line-buffer 3x3 window generator over a raster pixel stream; emits interior windows only.
// Optional completed-frame counter enabled by SW_FRAME_CNT_EN.
module sliding_window_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    sliding_window_3x3_if.slave   sw_if
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    lb1_q [IMG_W];
    logic [7:0]    lb2_q [IMG_W];
    logic [7:0]    win_q [9];
    logic          act_q;
    logic          frame_done_q;
    logic          accept;
    logic          last_col;
    logic          last_row;

    assign accept   = sw_if.in_valid;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Line buffers carry no reset; rows 0-1 after any reset rewrite them before a window uses them.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= sw_if.in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            act_q        <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            act_q        <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
            frame_done_q <= accept && last_row && last_col;
            if (accept) begin
                // win_q is row-major: [0..2] top (line r-2), [3..5] line r-1, [6..8] current line
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb2_q[col_q];
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_q[col_q];
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= sw_if.in_pixel;
            end
        end
    end

`ifdef SW_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign sw_if.frame_cnt = frame_cnt_q;
`endif

    assign sw_if.sw_pixels1 = win_q[0];
    assign sw_if.sw_pixels2 = win_q[1];
    assign sw_if.sw_pixels3 = win_q[2];
    assign sw_if.sw_pixels4 = win_q[3];
    assign sw_if.sw_pixels5 = win_q[4];
    assign sw_if.sw_pixels6 = win_q[5];
    assign sw_if.sw_pixels7 = win_q[6];
    assign sw_if.sw_pixels8 = win_q[7];
    assign sw_if.sw_pixels9 = win_q[8];
    assign sw_if.act        = act_q;
    assign sw_if.frame_done = frame_done_q;
endmodule

// File: tb/tb_sliding_window_3x3.sv
// Scoreboard bench for sliding_window_3x3 on a 5x4 image with pixel(r,c) = base + 10r + c.
// Covers continuous, gapped, back-to-back and mid-frame-reset streams; frame_cnt when SW_FRAME_CNT_EN is defined.
module tb_sliding_window_3x3;
    localparam int W = 5;
    localparam int H = 4;

    typedef struct packed {
        logic [71:0] px;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    logic acc_q = 1'b0;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pops = 0;
    int   win_in_frame = 0;

    sliding_window_3x3_if sw_if ();

    sliding_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_if (sw_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_q <= rst;
        acc_q <= sw_if.in_valid && !rst;
    end

    function automatic logic [71:0] window_of(input int base, input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int k = 0; k < 9; k++)
            v[71 - 8*k -: 8] = 8'(base + 10*(r - 2 + k/3) + (c - 2 + k%3));
        return v;
    endfunction

    task automatic drive_px(input int base, input int r, input int c);
        exp_t e;
        if (r >= 2 && c >= 2) begin
            e.px   = window_of(base, r, c);
            e.last = (r == H-1) && (c == W-1);
            exp_q.push_back(e);
            pushes++;
        end
        sw_if.in_valid = 1'b1;
        sw_if.in_pixel = 8'(base + 10*r + c);
        @(posedge clk);
        #1;
        sw_if.in_valid = 1'b0;
        sw_if.in_pixel = 8'hEE;
    endtask

    task automatic idle(input int n);
        sw_if.in_valid = 1'b0;
        sw_if.in_pixel = 8'hEE;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base, input bit gapped);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gapped)
                    while ($urandom_range(0, 1) == 0) idle(1);
                drive_px(base, r, c);
            end
    endtask

`ifdef SW_FRAME_CNT_EN
    logic [15:0] exp_fc = '0;
    bit          fd_pend = 1'b0;
`endif

    // Monitor: samples on the falling edge, pops one expected window per act.
    always @(negedge clk) begin
        logic [71:0] got;
        exp_t        e;
        got = {sw_if.sw_pixels1, sw_if.sw_pixels2, sw_if.sw_pixels3,
               sw_if.sw_pixels4, sw_if.sw_pixels5, sw_if.sw_pixels6,
               sw_if.sw_pixels7, sw_if.sw_pixels8, sw_if.sw_pixels9};
`ifdef SW_FRAME_CNT_EN
        if (rst_q) begin
            exp_fc  = '0;
            fd_pend = 1'b0;
        end else if (fd_pend) begin
            exp_fc  = exp_fc + 16'd1;
            fd_pend = 1'b0;
        end
        checks++;
        if (sw_if.frame_cnt !== exp_fc) begin
            errors++;
            $display("FAIL frame_cnt at %0t: got %0d expected %0d", $time, sw_if.frame_cnt, exp_fc);
        end
`endif
        if (rst_q) begin
            win_in_frame = 0;
            checks++;
            if (sw_if.act !== 1'b0 || sw_if.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs at %0t: act=%b frame_done=%b expected 0 0",
                         $time, sw_if.act, sw_if.frame_done);
            end
        end else if (sw_if.act === 1'b1) begin
            checks++;
            if (!acc_q) begin
                errors++;
                $display("FAIL act_without_accept at %0t: act=1 expected 0", $time);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window at %0t: got %h expected none", $time, got);
            end else begin
                e = exp_q.pop_front();
                pops++;
                win_in_frame++;
                checks++;
                if (got !== e.px || sw_if.frame_done !== e.last) begin
                    errors++;
                    $display("FAIL window at %0t: got %h fd=%b expected %h fd=%b",
                             $time, got, sw_if.frame_done, e.px, e.last);
                end
                if (e.last) begin
                    checks++;
                    if (win_in_frame != (W-2)*(H-2)) begin
                        errors++;
                        $display("FAIL windows_per_frame: got %0d expected %0d",
                                 win_in_frame, (W-2)*(H-2));
                    end
                    win_in_frame = 0;
`ifdef SW_FRAME_CNT_EN
                    fd_pend = 1'b1;
`endif
                end
            end
        end else begin
            checks++;
            if (sw_if.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL frame_done_without_act at %0t: frame_done=%b expected 0",
                         $time, sw_if.frame_done);
            end
        end
    end

    initial begin
        sw_if.in_valid = 1'b0;
        sw_if.in_pixel = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sw_if.sw_pixels1, sw_if.sw_pixels2, sw_if.sw_pixels3, sw_if.sw_pixels4,
             sw_if.sw_pixels5, sw_if.sw_pixels6, sw_if.sw_pixels7, sw_if.sw_pixels8,
             sw_if.sw_pixels9} !== 72'h0) begin
            errors++;
            $display("FAIL reset_window: got nonzero window expected all zero");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_frame(0, 1'b0);
        idle(3);
        send_frame(0, 1'b1);
        idle(2);
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);

        // Partial frame up to pixel (2,3), then reset with a pixel presented that must be dropped.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c <= 3) drive_px(0, r, c);
        rst = 1'b1;
        sw_if.in_valid = 1'b1;
        sw_if.in_pixel = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sw_if.in_valid = 1'b0;
        send_frame(0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        checks++;
        if (exp_q.size() != 0 || pops != pushes) begin
            errors++;
            $display("FAIL drain: pending %0d popped %0d expected 0 pending and %0d popped",
                     exp_q.size(), pops, pushes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
